// File: rtl/ahb_sram_bridge_if.sv
// rtl/ahb_sram_bridge_if.sv - AHB-Lite slave bus plus SRAM port signals for ahb_sram_bridge
interface ahb_sram_bridge_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;
    logic                  HREADY;
    logic [31:0]           HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic                  sram_en;
    logic [3:0]            sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_wdata;
    logic [31:0]           sram_rdata;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_rdata,
        output HRDATA, HREADYOUT, HRESP, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, sram_rdata,
        input  HRDATA, HREADYOUT, HRESP, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/ahb_sram_bridge.sv
// rtl/ahb_sram_bridge.sv - zero-wait AHB-Lite slave for a byte-write SRAM with a one-entry write buffer
module ahb_sram_bridge #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_sram_bridge_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

    state_t                r_state;
    logic                  r_hreadyout;
    logic                  r_hresp;
    logic                  r_wdp;
    logic [ADDR_WIDTH-1:0] r_wa_addr;
    logic [3:0]            r_wa_mask;
    logic                  r_buf_valid;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [3:0]            r_buf_mask;
    logic [31:0]           r_buf_data;
    logic                  r_rdp;
    logic                  r_hit;

    logic [ADDR_WIDTH-1:0] w_word;
    logic [3:0]            w_mask;
    logic                  w_acc;
    logic                  w_err;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_data_end;
    logic                  w_direct;
    logic                  w_load;
    logic                  w_hit;
    logic                  w_unused;

    assign w_unused = ^bus.HADDR[31:ADDR_WIDTH+2];

    always_comb begin
        w_word = bus.HADDR[ADDR_WIDTH+1:2];
        case (bus.HSIZE)
            3'd0:    w_mask = 4'b0001 << bus.HADDR[1:0];
            3'd1:    w_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        w_acc = bus.HSEL & bus.HREADY & bus.HTRANS[1] & (r_state != S_ERR1);
        w_err = w_acc & ((bus.HSIZE > 3'd2) |
                         ((bus.HSIZE == 3'd1) & bus.HADDR[0]) |
                         ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00)));
        w_rd  = w_acc & ~w_err & ~bus.HWRITE;
        w_wr  = w_acc & ~w_err & bus.HWRITE;
        w_data_end = r_wdp & bus.HREADY;
        // With the buffer empty and the port free, the finished write goes straight to the
        // SRAM; only a write whose data phase overlaps a read is parked. This keeps wr,wr,rd
        // sequences within a single buffer entry.
        w_direct = w_data_end & ~w_rd & ~r_buf_valid;
        w_load   = w_data_end & ~w_direct;
        w_hit    = w_rd & (r_wdp ? (w_word == r_wa_addr)
                                 : (r_buf_valid & (w_word == r_buf_addr)));
    end

    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_we    = 4'b0000;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (w_rd) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = w_word;
        end else if (r_buf_valid) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = r_buf_mask;
            bus.sram_addr  = r_buf_addr;
            bus.sram_wdata = r_buf_data;
        end else if (w_direct) begin
            bus.sram_en    = 1'b1;
            bus.sram_we    = r_wa_mask;
            bus.sram_addr  = r_wa_addr;
            bus.sram_wdata = bus.HWDATA;
        end
    end

    always_comb begin
        bus.HRDATA = '0;
        if (r_rdp) begin
            for (int i = 0; i < 4; i++) begin
                bus.HRDATA[8*i +: 8] = (r_hit & r_buf_mask[i]) ? r_buf_data[8*i +: 8]
                                                               : bus.sram_rdata[8*i +: 8];
            end
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_wdp       <= 1'b0;
            r_wa_addr   <= '0;
            r_wa_mask   <= 4'b0000;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_mask  <= 4'b0000;
            r_buf_data  <= '0;
            r_rdp       <= 1'b0;
            r_hit       <= 1'b0;
        end else begin
            r_rdp <= w_rd;
            r_hit <= w_hit;

            if (w_wr) begin
                r_wdp     <= 1'b1;
                r_wa_addr <= w_word;
                r_wa_mask <= w_mask;
            end else if (w_data_end) begin
                r_wdp <= 1'b0;
            end

            // A load in the same cycle as a commit replaces the old entry after it was written.
            if (w_load) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= r_wa_addr;
                r_buf_mask  <= r_wa_mask;
                r_buf_data  <= bus.HWDATA;
            end else if (r_buf_valid & ~w_rd) begin
                r_buf_valid <= 1'b0;
            end

            case (r_state)
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    if (w_err) begin
                        r_state     <= S_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_sram_bridge.sv
// tb/tb_ahb_sram_bridge.sv - directed scoreboard bench for ahb_sram_bridge
module tb_ahb_sram_bridge;
    localparam int AW = 13;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold = 1'b0;
    logic rd_flag = 1'b0;
    logic rd_dp = 1'b0;
    logic [31:0] rdata_q = '0;
    logic [31:0] pend_wdata = '0;
    logic [31:0] mem [int];

    logic [31:0] rd_q [$];
    wr_t         wr_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    logic          cap_ready, cap_resp, cap_en;
    logic [3:0]    cap_we;
    logic [AW-1:0] cap_addr;

    always #5 clk = ~clk;

    ahb_sram_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    ahb_sram_bridge #(.ADDR_WIDTH(AW)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    assign bus.HREADY     = hold ? 1'b0 : bus.HREADYOUT;
    assign bus.sram_rdata = rdata_q;

    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (bus.sram_en) begin
            w = mem.exists(int'(bus.sram_addr)) ? mem[int'(bus.sram_addr)] : 32'h0;
            rdata_q <= w;
            for (int i = 0; i < 4; i++)
                if (bus.sram_we[i]) w[8*i +: 8] = bus.sram_wdata[8*i +: 8];
            mem[int'(bus.sram_addr)] = w;
        end
    end

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        logic [31:0] ed;
        if (rd_dp) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read_phase", 32'd1, 32'd0);
            end else begin
                ed = rd_q.pop_front();
                check("hrdata", bus.HRDATA, ed);
                check("rd_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
            end
        end
        if (bus.sram_en && bus.sram_we != 4'b0000) begin
            if (wr_q.size() == 0) begin
                check("unexpected_sram_write", {28'b0, bus.sram_we}, 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("commit_addr", {{(32-AW){1'b0}}, bus.sram_addr}, {{(32-AW){1'b0}}, e.addr});
                check("commit_we", {28'b0, bus.sram_we}, {28'b0, e.we});
                check("commit_data", bus.sram_wdata & lanes(bus.sram_we), e.data & lanes(e.we));
            end
        end
        rd_dp = rd_flag;
    end

    task automatic cycle(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input logic is_rd);
        bus.HSEL   = 1'b1;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        bus.HWDATA = pend_wdata;
        rd_flag    = is_rd;
        if (trans[1]) pend_wdata = wdata;
        @(negedge clk);
        cap_ready = bus.HREADYOUT;
        cap_resp  = bus.HRESP;
        cap_en    = bus.sram_en;
        cap_we    = bus.sram_we;
        cap_addr  = bus.sram_addr;
        @(posedge clk);
        #1;
        rd_flag = 1'b0;
    endtask

    task automatic idle();
        cycle(2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [2:0] size,
                      input logic [3:0] mask, input logic [31:0] data);
        logic [AW-1:0] word;
        word = addr[AW+1:2];
        wr_q.push_back('{word, mask, data});
        cycle(2'b10, 1'b1, addr, size, data, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        rd_q.push_back(exp);
        cycle(2'b10, 1'b0, addr, 3'd2, 32'h0, 1'b1);
    endtask

    task automatic err_seq(input logic w, input logic [31:0] addr, input logic [2:0] size);
        cycle(2'b10, w, addr, size, 32'hFFFF_FFFF, 1'b0);
        check("err_addr_sram_en", {31'b0, cap_en}, 32'd0);
        idle();
        check("err1_ready", {31'b0, cap_ready}, 32'd0);
        check("err1_resp", {31'b0, cap_resp}, 32'd1);
        check("err1_sram_en", {31'b0, cap_en}, 32'd0);
        idle();
        check("err2_ready", {31'b0, cap_ready}, 32'd1);
        check("err2_resp", {31'b0, cap_resp}, 32'd1);
        idle();
        check("err_done_resp", {31'b0, cap_resp}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ready_all;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
        bus.HADDR = '0; bus.HSIZE = 3'd0; bus.HWDATA = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        check("rst_hresp", {31'b0, bus.HRESP}, 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_sram_en", {31'b0, bus.sram_en}, 32'd0);
        check("rst_sram_we", {28'b0, bus.sram_we}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();

        // 1: write, commit on first idle, read back
        wr(32'h10, 3'd2, 4'hF, 32'hDEAD_BEEF);
        idle();
        check("t1_commit_we", {28'b0, cap_we}, 32'hF);
        check("t1_commit_addr", {{(32-AW){1'b0}}, cap_addr}, 32'd4);
        idle(); idle();
        rd(32'h10, 32'hDEAD_BEEF);
        idle();

        // 2: read-after-write merges from the buffer, then a byte merge
        wr(32'h20, 3'd2, 4'hF, 32'h1111_1111);
        rd(32'h20, 32'h1111_1111);
        idle();
        wr(32'h21, 3'd0, 4'b0010, 32'h0000_AA00);
        rd(32'h20, 32'h1111_AA11);
        idle();

        // 3: streamed writes then reads, no wait states
        ready_all = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(32'(i * 4), 3'd2, 4'hF, 32'hC0DE_0000 | 32'(i));
            ready_all &= cap_ready;
        end
        for (int i = 0; i < 8; i++) begin
            rd(32'(i * 4), 32'hC0DE_0000 | 32'(i));
            ready_all &= cap_ready;
        end
        idle();
        ready_all &= cap_ready;
        check("t3_hreadyout_never_low", {31'b0, ready_all}, 32'd1);
        idle();

        // 4: misaligned word and oversize transfers
        err_seq(1'b0, 32'h02, 3'd2);
        err_seq(1'b1, 32'h00, 3'd3);
        err_seq(1'b1, 32'h01, 3'd1);
        rd(32'h00, 32'hC0DE_0000);
        idle();

        // 5: reset before the commit discards the write
        cycle(2'b10, 1'b1, 32'h40, 3'd2, 32'h1234_5678, 1'b0);
        rst_n = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = 32'h1234_5678;
        @(negedge clk);
        check("t5_rst_sram_en", {31'b0, bus.sram_en}, 32'd0);
        check("t5_rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
        check("t5_rst_hrdata", bus.HRDATA, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        rd(32'h40, 32'h0);
        idle();

        // 6: half write with a stretched data phase
        wr(32'h32, 3'd1, 4'b1100, 32'hBEEF_0000);
        hold = 1'b1;
        idle();
        check("t6_hold1_sram_en", {31'b0, cap_en}, 32'd0);
        idle();
        check("t6_hold2_sram_en", {31'b0, cap_en}, 32'd0);
        hold = 1'b0;
        idle();
        check("t6_commit_we", {28'b0, cap_we}, 32'hC);
        rd(32'h30, 32'hBEEF_0000);
        idle();
        idle();

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
